dm_responder: RTL and testbench

- Memory-side responder for the CPU data-memory port: accepts one load/store request at a time over a valid/ready handshake.
- Holds 2^ADDR_W 32-bit words.
- Inserts a programmable number of wait cycles, then returns the response over a valid/ready handshake with backpressure.
- Replaces the zero-wait dm_2k model when a multi-cycle or bus-attached core is built.

---
 rtl/dm_responder.sv | 110 +++++++++++
 tb/tb_dm_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding load/store, LATENCY wait cycles,
// then a response held under backpressure until the requester takes it.
module dm_responder #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_we
);

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
            $error("dm_responder: LATENCY must be in 0..15");
        end
    endgenerate

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;
    logic                rsp_we_q;
    logic [31:0]         mem_q [2**ADDR_W];
    logic [31:0]         wr_word_d;

    // Read-modify-write merge of the latched store into the addressed word.
    always_comb begin
        wr_word_d = mem_q[addr_q];
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) wr_word_d[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        we_q        <= req_we;
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        cnt_q       <= LAT4;
                        req_ready_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (we_q) begin
                            mem_q[addr_q] <= wr_word_d;
                            rsp_rdata_q   <= '0;
                        end else begin
                            rsp_rdata_q   <= mem_q[addr_q];
                        end
                        rsp_we_q    <= we_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // ready is raised only once back in IDLE, so no accept on the handshake edge
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_we    = rsp_we_q;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized bench for dm_responder: three instances (LATENCY 0/2/4) checked
// against a word-array memory model and a cycle-count latency rule.
module tb_dm_responder;

    logic        clk;
    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [8:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_we    [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl  [3][512];
    logic [8:0]  pool [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_responder #(.ADDR_W(9), .LATENCY(2 * g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_we    (rsp_we[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full transaction on instance k; entered and left at a negedge with the DUT idle.
    task automatic txn(input int k, input bit we, input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int stall, output logic [31:0] got);
        logic [31:0] exp;
        int cyc;
        chk($sformatf("idle_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a;
        req_wdata[k] = d;    req_be[k] = be;
        rsp_ready[k] = (stall == 0);
        tick();
        req_valid[k] = 1'b0;
        req_we[k] = 1'($urandom); req_addr[k] = 9'($urandom);
        req_wdata[k] = $urandom;  req_be[k] = 4'($urandom);
        if (we) begin
            exp = 32'd0;
            mdl[k][a] = merge(mdl[k][a], d, be);
        end else begin
            exp = mdl[k][a];
        end
        cyc = 0;
        while (!rsp_valid[k] && cyc < 40) begin
            chk($sformatf("busy_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
            tick();
            cyc++;
        end
        chk($sformatf("latency[%0d]", k), 32'(cyc), 32'(2 * k + 1));
        chk($sformatf("rsp_we[%0d]", k), 32'(rsp_we[k]), 32'(we));
        chk($sformatf("rdata[%0d]", k), rsp_rdata[k], exp);
        got = rsp_rdata[k];
        for (int s = 0; s < stall; s++) begin
            if (s == 1) begin
                req_valid[k] = 1'b1; req_we[k] = 1'b1; req_be[k] = 4'hF;
                req_addr[k] = pool[$urandom_range(15)]; req_wdata[k] = $urandom;
            end
            tick();
            req_valid[k] = 1'b0;
            chk($sformatf("stall_valid[%0d]", k), 32'(rsp_valid[k]), 32'd1);
            chk($sformatf("stall_rdata[%0d]", k), rsp_rdata[k], exp);
            chk($sformatf("stall_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
        end
        rsp_ready[k] = 1'b1;
        tick();
        chk($sformatf("post_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
        chk($sformatf("post_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        int cyc;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0;   req_be[k] = '0;  rsp_ready[k] = 1'b1;
        end
        pool[0] = 9'h000; pool[1] = 9'h010; pool[2] = 9'h020; pool[3] = 9'h1FF;
        for (int i = 4; i < 16; i++) pool[i] = 9'(i * 29);

        // Reset held for two edges
        @(negedge clk);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("rst_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", k), rsp_rdata[k], 32'd0);
            chk($sformatf("rst_we[%0d]", k), 32'(rsp_we[k]), 32'd0);
        end
        rst = 1'b1;

        // Give every pooled word a known value
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++)
                txn(k, 1'b1, pool[i], $urandom, 4'hF, 0, got);

        // Full-word store then load, then byte-enable merge (LATENCY=2)
        txn(1, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 0, got);
        txn(1, 1'b0, 9'h010, 32'h0, 4'h0, 0, got);
        chk("load_deadbeef", got, 32'hDEADBEEF);
        txn(1, 1'b1, 9'h010, 32'h11223344, 4'b0101, 0, got);
        txn(1, 1'b0, 9'h010, 32'h0, 4'h0, 0, got);
        chk("load_merged", got, 32'hDE22BE44);

        // Backpressure with an ignored request pulse
        txn(1, 1'b0, 9'h010, 32'h0, 4'h0, 5, got);
        txn(1, 1'b0, 9'h010, 32'h0, 4'h0, 0, got);

        // Store with no byte enables leaves memory alone
        txn(0, 1'b1, 9'h1FF, 32'h12345678, 4'h0, 0, got);
        txn(0, 1'b0, 9'h1FF, 32'h0, 4'h0, 0, got);

        // Reset two edges after acceptance discards the pending store (LATENCY=4)
        txn(2, 1'b1, 9'h020, 32'h0, 4'hF, 0, got);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 9'h020;
        req_wdata[2] = 32'hCAFEF00D; req_be[2] = 4'hF;
        tick();
        req_valid[2] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstwait_ready", 32'(req_ready[2]), 32'd1);
        chk("rstwait_valid", 32'(rsp_valid[2]), 32'd0);
        txn(2, 1'b0, 9'h020, 32'h0, 4'h0, 0, got);
        chk("rstwait_load", got, 32'h00000000);

        // Reset while holding a store response: the write survives
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = pool[5];
        req_wdata[1] = 32'hAAAA5555; req_be[1] = 4'hF;
        tick();
        req_valid[1] = 1'b0;
        mdl[1][pool[5]] = 32'hAAAA5555;
        cyc = 0;
        while (!rsp_valid[1] && cyc < 40) begin tick(); cyc++; end
        chk("rstresp_lat", 32'(cyc), 32'd3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rsp_ready[1] = 1'b1;
        chk("rstresp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rstresp_ready", 32'(req_ready[1]), 32'd1);
        chk("rstresp_rdata", rsp_rdata[1], 32'd0);
        txn(1, 1'b0, pool[5], 32'h0, 4'h0, 0, got);

        // LATENCY=0 with req_valid held: accepts at E and E+3
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = pool[1];
        tick();
        chk("b2b_busy0", 32'(req_ready[0]), 32'd0);
        chk("b2b_wait0", 32'(rsp_valid[0]), 32'd0);
        req_addr[0] = pool[2];
        tick();
        chk("b2b_valid0", 32'(rsp_valid[0]), 32'd1);
        chk("b2b_rdata0", rsp_rdata[0], mdl[0][pool[1]]);
        tick();
        chk("b2b_idle", 32'(req_ready[0]), 32'd1);
        chk("b2b_drop", 32'(rsp_valid[0]), 32'd0);
        tick();
        chk("b2b_busy1", 32'(req_ready[0]), 32'd0);
        req_valid[0] = 1'b0;
        tick();
        chk("b2b_valid1", 32'(rsp_valid[0]), 32'd1);
        chk("b2b_rdata1", rsp_rdata[0], mdl[0][pool[2]]);
        tick();
        chk("b2b_end", 32'(req_ready[0]), 32'd1);

        // Random traffic over the pooled addresses
        for (int n = 0; n < 150; n++) begin
            txn($urandom_range(2), 1'($urandom), pool[$urandom_range(15)], $urandom,
                4'($urandom), ($urandom_range(3) == 0) ? $urandom_range(4, 1) : 0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
